// File: rtl/lb_pkg.sv
// Shared types and constants for the line buffer group controller:
// FSM states, window geometry and the window element indexing helper.
package lb_pkg;

  localparam int LB_D_WIDTH = 16;

  typedef logic [LB_D_WIDTH-1:0] win_elem_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } lb_state_t;

  localparam int WIN_ROWS  = 3;
  localparam int WIN_COLS  = 3;
  localparam int WIN_ELEMS = WIN_ROWS * WIN_COLS;

  // Window rows: top is the oldest image row (buffer II), bottom is the live pixel.
  localparam int WIN_TOP = 0;
  localparam int WIN_MID = 1;
  localparam int WIN_BOT = 2;

  function automatic int win_idx(input int row, input int col);
    return WIN_COLS * row + col;
  endfunction

endpackage

// File: rtl/line_buffer_window_regs.sv
// 3x3 window shift register: each shift moves the window one column left and
// loads a new right-hand column; the window is presented packed, element 3*row+col.
module line_buffer_window_regs
  import lb_pkg::*;
#(
  parameter int D_WIDTH = LB_D_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         shift,
  input  logic [D_WIDTH-1:0]           col_top,
  input  logic [D_WIDTH-1:0]           col_mid,
  input  logic [D_WIDTH-1:0]           col_bot,
  output logic [WIN_ELEMS*D_WIDTH-1:0] win_data
);

  logic [D_WIDTH-1:0] win_r  [WIN_ROWS][WIN_COLS];
  logic [D_WIDTH-1:0] col_in [WIN_ROWS];

  // Route the incoming column onto window rows.
  always_comb begin
    col_in[WIN_TOP] = col_top;
    col_in[WIN_MID] = col_mid;
    col_in[WIN_BOT] = col_bot;
  end

  // Column shift; the newest column enters at the right (col 2).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIN_ROWS; i++) begin
        for (int j = 0; j < WIN_COLS; j++) begin
          win_r[i][j] <= '0;
        end
      end
    end else if (shift) begin
      for (int i = 0; i < WIN_ROWS; i++) begin
        for (int j = 0; j < WIN_COLS - 1; j++) begin
          win_r[i][j] <= win_r[i][j+1];
        end
        win_r[i][WIN_COLS-1] <= col_in[i];
      end
    end
  end

  // Pack the registered window onto the output bus.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < WIN_ROWS; i++) begin
      for (int j = 0; j < WIN_COLS; j++) begin
        win_data[win_idx(i, j)*D_WIDTH +: D_WIDTH] = win_r[i][j];
      end
    end
  end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line buffer group controller: turns a raster pixel stream into sliding 3x3
// windows using two external SRAM line buffers (I holds row r-1, II holds row r-2).
module line_buffer_ctrl
  import lb_pkg::*;
#(
  parameter int D_WIDTH    = LB_D_WIDTH,
  parameter int ADDR_BITS  = 5,
  parameter int IMG_WIDTH  = 30,
  parameter int IMG_HEIGHT = 30,
  parameter int CNT_BITS   = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [D_WIDTH-1:0]           in_data,
  output logic                         busy,
  output logic [ADDR_BITS-1:0]         lb_rd_addr_I,
  output logic [ADDR_BITS-1:0]         lb_rd_addr_II,
  input  logic [D_WIDTH-1:0]           lb_rd_data_I,
  input  logic [D_WIDTH-1:0]           lb_rd_data_II,
  output logic [ADDR_BITS-1:0]         lb_wr_addr_I,
  output logic [ADDR_BITS-1:0]         lb_wr_addr_II,
  output logic                         lb_wr_en_I,
  output logic                         lb_wr_en_II,
  output logic [D_WIDTH-1:0]           lb_wr_data_I,
  output logic [D_WIDTH-1:0]           lb_wr_data_II,
  output logic                         win_valid,
  output logic [WIN_ELEMS*D_WIDTH-1:0] win_data,
  output logic [CNT_BITS-1:0]          win_row,
  output logic [CNT_BITS-1:0]          win_col,
  output logic                         frame_done
);

  localparam logic [CNT_BITS-1:0] COL_LAST  = CNT_BITS'(IMG_WIDTH - 1);
  localparam logic [CNT_BITS-1:0] ROW_LAST  = CNT_BITS'(IMG_HEIGHT - 1);
  localparam logic [CNT_BITS-1:0] FILL_LAST = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] WIN_OFS   = CNT_BITS'(2);

  lb_state_t           state_r;
  lb_state_t           state_nxt;
  logic [CNT_BITS-1:0] row_r;
  logic [CNT_BITS-1:0] col_r;
  logic                accept_s;
  logic                row_end_s;
  logic                frame_end_s;
  logic                start_ok_s;

  logic                acc_d_r;
  logic [D_WIDTH-1:0]  pix_d_r;
  logic [CNT_BITS-1:0] row_d_r;
  logic [CNT_BITS-1:0] col_d_r;
  logic                last_d_r;
  logic                last_d2_r;

  logic                win_valid_r;
  logic [CNT_BITS-1:0] win_row_r;
  logic [CNT_BITS-1:0] win_col_r;
  logic                frame_done_r;

  // A pixel is never taken in the reset cycle, so an aborted frame leaves no trace.
  assign accept_s    = in_valid && in_ready && !rst;
  assign row_end_s   = (col_r == COL_LAST);
  assign frame_end_s = row_end_s && (row_r == ROW_LAST);
  assign start_ok_s  = start && ((state_r == IDLE) || (state_r == DONE));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt = FILL;
        else       state_nxt = IDLE;
      end
      FILL: begin
        if (accept_s && row_end_s && (row_r == FILL_LAST)) state_nxt = STREAM;
        else                                                state_nxt = FILL;
      end
      STREAM: begin
        if (accept_s && frame_end_s) state_nxt = DONE;
        else                         state_nxt = STREAM;
      end
      DONE: begin
        if (start) state_nxt = FILL;
        else       state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_r)
      FILL, STREAM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Raster position of the next pixel; row holds at the last row once the frame ends.
  always_ff @(posedge clk) begin
    if (rst || start_ok_s) begin
      row_r <= '0;
      col_r <= '0;
    end else if (accept_s) begin
      if (row_end_s) begin
        col_r <= '0;
        if (!frame_end_s) row_r <= row_r + CNT_BITS'(1);
      end else begin
        col_r <= col_r + CNT_BITS'(1);
      end
    end
  end

  // Accept-delayed stage: drives buffer writes and the window column shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_d_r  <= 1'b0;
      pix_d_r  <= '0;
      row_d_r  <= '0;
      col_d_r  <= '0;
      last_d_r <= 1'b0;
    end else begin
      acc_d_r  <= accept_s;
      last_d_r <= accept_s && frame_end_s;
      if (accept_s) begin
        pix_d_r <= in_data;
        row_d_r <= row_r;
        col_d_r <= col_r;
      end
    end
  end

  // Window qualification; column gating keeps windows from straddling a row wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_r  <= 1'b0;
      win_row_r    <= '0;
      win_col_r    <= '0;
      last_d2_r    <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      win_valid_r  <= acc_d_r && (row_d_r >= WIN_OFS) && (col_d_r >= WIN_OFS);
      last_d2_r    <= last_d_r;
      frame_done_r <= last_d2_r;
      if (acc_d_r) begin
        win_row_r <= row_d_r - WIN_OFS;
        win_col_r <= col_d_r - WIN_OFS;
      end
    end
  end

  assign lb_rd_addr_I  = ADDR_BITS'(col_r);
  assign lb_rd_addr_II = ADDR_BITS'(col_r);

  // Rotation: I takes the live pixel, II takes what I held at this column.
  assign lb_wr_en_I    = acc_d_r && !rst;
  assign lb_wr_en_II   = acc_d_r && !rst;
  assign lb_wr_addr_I  = ADDR_BITS'(col_d_r);
  assign lb_wr_addr_II = ADDR_BITS'(col_d_r);
  assign lb_wr_data_I  = pix_d_r;
  assign lb_wr_data_II = lb_wr_en_I ? lb_rd_data_I : '0;

  assign win_valid  = win_valid_r;
  assign win_row    = win_row_r;
  assign win_col    = win_col_r;
  assign frame_done = frame_done_r;

  line_buffer_window_regs #(
    .D_WIDTH (D_WIDTH)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .shift    (acc_d_r),
    .col_top  (lb_rd_data_II),
    .col_mid  (lb_rd_data_I),
    .col_bot  (pix_d_r),
    .win_data (win_data)
  );

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
Sequences one line buffer group (two SRAM line buffers, I and II) so a raster-ordered ifmap pixel stream becomes a sliding 3x3 convolution window.
- Generates the read/write addresses, write enables and write data for both buffers, and rotates rows I -> II.
- Assembles 3x3 windows from the buffer read data plus the live pixel, and emits them with coordinates.
- One instance sits per group, between the ifmap input stream and the convolution PE array.

Parameters:
D_WIDTH, 16, pixel width in bits
ADDR_BITS, 5, line buffer address width
IMG_WIDTH, 30, pixels per row (28 + 2 padding); must be <= 2**ADDR_BITS and >= 3
IMG_HEIGHT, 30, rows per frame; must be >= 3
CNT_BITS, 5, row/column counter width; must satisfy 2**CNT_BITS >= max(IMG_WIDTH, IMG_HEIGHT)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  pulse; begins a frame when in IDLE or DONE
in_valid  in  1  in_data valid
in_ready  out  1  controller accepts a pixel; a pixel transfers when in_valid && in_ready
in_data  in  D_WIDTH  ifmap pixel, raster order
busy  out  1  high in FILL and STREAM
lb_rd_addr_I, lb_rd_addr_II  out  ADDR_BITS  buffer read addresses
lb_rd_data_I, lb_rd_data_II  in  D_WIDTH  read data, 1-cycle SRAM latency
lb_wr_addr_I, lb_wr_addr_II  out  ADDR_BITS  buffer write addresses
lb_wr_en_I, lb_wr_en_II  out  1  buffer write enables
lb_wr_data_I, lb_wr_data_II  out  D_WIDTH  buffer write data
win_valid  out  1  win_data holds a complete window
win_data  out  9*D_WIDTH  window element k = 3*row + col at bits [(k+1)*D_WIDTH-1 : k*D_WIDTH]; row 0 is oldest (top), col 0 is oldest (left)
win_row, win_col  out  CNT_BITS  top-left coordinate of the window in the ifmap
frame_done  out  1  one-cycle pulse after the last window

Behaviour:
- Reset: state IDLE; counters 0; all outputs 0, including in_ready, busy, win_valid, frame_done, all lb_* outputs and win_data. Reset mid-frame aborts the frame; no writes are issued in the reset cycle; the next frame needs a new start.
- States:
  - IDLE: start -> FILL.
  - FILL: rows 0-1 accepted; after the last pixel of row 1 -> STREAM.
  - STREAM: after the last pixel of row IMG_HEIGHT-1 is accepted -> DONE.
  - DONE: frame_done asserts once the last window has emitted; start -> FILL.
  - start is ignored while busy.
- in_ready = 1 in FILL and STREAM, 0 otherwise. No downstream back-pressure.
- Accept cycle t, pixel at (r,c):
  - lb_rd_addr_I = lb_rd_addr_II = c in cycle t.
  - Cycle t+1: lb_wr_en_I = lb_wr_en_II = 1, both write addresses = c, lb_wr_data_I = delayed pixel, lb_wr_data_II = lb_rd_data_I. The SRAM must return old data on same-address read-during-write.
  - Column vector {lb_rd_data_II, lb_rd_data_I, pixel} is shifted into the 3x3 window register at t+1.
- Window output:
  - win_valid = 1 at cycle t+2 iff r >= 2 and c >= 2.
  - win_row = r-2, win_col = c-2.
  - Windows never straddle a row wrap because validity is gated on c >= 2.
  - Contents of rows 0-1 and windows gated invalid are don't-care.
- in_valid gaps freeze the column shift and address counters; no writes occur on non-accept cycles.
- Counters: c wraps IMG_WIDTH-1 -> 0 and increments r; r saturates at end of frame. Exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame.
- frame_done pulses in the cycle after the last win_valid, i.e. t_last+3. Back-to-back frames: a start on the frame_done cycle is honoured.

Decomposition:
- Package lb_pkg: D_WIDTH default, window element typedef, state enum {IDLE, FILL, STREAM, DONE}, window element index constants.
- Sub-module line_buffer_window_regs: 3x3 shift register with shift enable and packed win_data output.

Test Plan:
1. IMG_WIDTH = IMG_HEIGHT = 4, pixel = 16*r + c, continuous in_valid -> 4 windows; the first has win_row=0, win_col=0, win_data elements 0..8 = {00,01,02,10,11,12,20,21,22} hex, two cycles after (2,2) is accepted; the last = {11,12,13,21,22,23,31,32,33}; frame_done one cycle after it.
2. Same image with in_valid toggling 1,0,0,1,... -> identical window sequence and values; no lb_wr_en on gap cycles.
3. Default 30x30 frame with random pixels -> exactly 784 win_valid pulses, each matching a software reference; win_col spans 0..27 per row; one frame_done.
4. rst asserted after 10 pixels of row 2 -> next cycle all outputs 0, state IDLE; new start plus a full frame gives correct windows.
5. start pulsed during STREAM -> ignored; window count unaffected; start on the frame_done cycle starts a second frame with no idle gap.
6. Address check: at accept of (3,5), lb_rd_addr_I/II = 5; next cycle both write addresses = 5 and lb_wr_data_II = the value previously written to I at address 5.
